// File: rtl/ibex_rf_write_arbiter.sv
// Merges EX results and LSU load responses onto the single register file write port.
// Latency: 1 cycle to rf_we_o (LSU always; EX via bypass when idle). Backpressure: ex_ready_o low when the EX FIFO is full; LSU has no backpressure.
// Optional forwarding outputs are present only when IBEX_RF_WB_FWD_EN is defined.
module ibex_rf_write_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ExDepth   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,

    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_hit_a_o,
    output logic                 fwd_hit_b_o,
    output logic [DataWidth-1:0] fwd_data_a_o,
    output logic [DataWidth-1:0] fwd_data_b_o,

    output logic [31:0]          pending_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = $clog2(ExDepth);
    localparam int unsigned CntW = $clog2(ExDepth + 1);

    logic [4:0]           fifo_addr_q [ExDepth];
    logic [DataWidth-1:0] fifo_data_q [ExDepth];
    logic [PtrW-1:0]      rptr_q, wptr_q;
    logic [CntW-1:0]      cnt_q;

    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [DataWidth-1:0] rf_wdata_q;

    logic ex_keep, lsu_keep, fifo_empty, bypass, pop, push;

    assign ex_ready_o = (cnt_q < CntW'(ExDepth));
    assign fifo_empty = (cnt_q == '0);

    // x0 results complete their handshake but go nowhere.
    assign ex_keep  = ex_valid_i & ex_ready_o & (ex_waddr_i != 5'd0);
    assign lsu_keep = lsu_valid_i & (lsu_waddr_i != 5'd0);

    assign bypass = ex_keep & fifo_empty & ~lsu_keep;
    assign pop    = ~lsu_keep & ~fifo_empty;
    assign push   = ex_keep & ~bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < ExDepth; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (lsu_keep) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= lsu_waddr_i;
                rf_wdata_q <= lsu_wdata_i;
            end else if (pop) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= fifo_addr_q[rptr_q];
                rf_wdata_q <= fifo_data_q[rptr_q];
            end else if (bypass) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= ex_waddr_i;
                rf_wdata_q <= ex_wdata_i;
            end else begin
                rf_we_q    <= 1'b0;
            end

            // ExDepth is a power of two, so pointers wrap by natural overflow.
            if (push) begin
                fifo_addr_q[wptr_q] <= ex_waddr_i;
                fifo_data_q[wptr_q] <= ex_wdata_i;
                wptr_q              <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = ~fifo_empty | rf_we_q;

    always_comb begin
        logic [PtrW-1:0] idx;
        pending_o = '0;
        idx       = '0;
        if (rf_we_q) begin
            pending_o[rf_waddr_q] = 1'b1;
        end
        for (int k = 0; k < ExDepth; k++) begin
            idx = rptr_q + PtrW'(k);
            if (CntW'(k) < cnt_q) begin
                pending_o[fifo_addr_q[idx]] = 1'b1;
            end
        end
    end

`ifdef IBEX_RF_WB_FWD_EN
    // Walk oldest to newest so the youngest matching entry wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx          = '0;
        fwd_hit_a_o  = 1'b0;
        fwd_hit_b_o  = 1'b0;
        fwd_data_a_o = '0;
        fwd_data_b_o = '0;
        if (rf_we_q && (raddr_a_i != 5'd0) && (rf_waddr_q == raddr_a_i)) begin
            fwd_hit_a_o  = 1'b1;
            fwd_data_a_o = rf_wdata_q;
        end
        if (rf_we_q && (raddr_b_i != 5'd0) && (rf_waddr_q == raddr_b_i)) begin
            fwd_hit_b_o  = 1'b1;
            fwd_data_b_o = rf_wdata_q;
        end
        for (int k = 0; k < ExDepth; k++) begin
            idx = rptr_q + PtrW'(k);
            if (CntW'(k) < cnt_q) begin
                if ((raddr_a_i != 5'd0) && (fifo_addr_q[idx] == raddr_a_i)) begin
                    fwd_hit_a_o  = 1'b1;
                    fwd_data_a_o = fifo_data_q[idx];
                end
                if ((raddr_b_i != 5'd0) && (fifo_addr_q[idx] == raddr_b_i)) begin
                    fwd_hit_b_o  = 1'b1;
                    fwd_data_b_o = fifo_data_q[idx];
                end
            end
        end
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr_a_i, raddr_b_i};
    assign fwd_hit_a_o  = 1'b0;
    assign fwd_hit_b_o  = 1'b0;
    assign fwd_data_a_o = '0;
    assign fwd_data_b_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Scoreboard bench for ibex_rf_write_arbiter: expected writes (address, data, cycle) are queued by
// the stimulus and consumed by an independent monitor whenever rf_we_o is high.
module tb_ibex_rf_write_arbiter;

`ifdef IBEX_RF_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic        fwd_hit_a_o, fwd_hit_b_o;
    logic [31:0] fwd_data_a_o, fwd_data_b_o;
    logic [31:0] pending_o;
    logic        busy_o;

    ibex_rf_write_arbiter #(.DataWidth(32), .ExDepth(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o),
        .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o),
        .pending_o(pending_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc_n = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input int delta);
        wr_t w;
        w.a = a;
        w.d = d;
        w.c = cyc_n + delta;
        sb.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ex_valid_i  = 1'b0;
        ex_waddr_i  = '0;
        ex_wdata_i  = '0;
        lsu_valid_i = 1'b0;
        lsu_waddr_i = '0;
        lsu_wdata_i = '0;
    endtask

    // Monitor: every write must match the oldest expected write, at the expected cycle.
    always @(negedge clk_i) begin
        if (rf_we_o) begin
            wr_t w;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=x%0d:%h expected=none (cycle %0d)",
                         rf_waddr_o, rf_wdata_o, cyc_n);
            end else begin
                w = sb.pop_front();
                if (rf_waddr_o !== w.a || rf_wdata_o !== w.d || cyc_n != w.c) begin
                    bad++;
                    $display("FAIL write actual=x%0d:%h@%0d expected=x%0d:%h@%0d",
                             rf_waddr_o, rf_wdata_o, cyc_n, w.a, w.d, w.c);
                end
            end
        end
    end

    initial begin
        int e;
        bit hs;
        logic exp_rdy [8];
        int base;

        // Reset with both sources active.
        rst_ni = 1'b0;
        raddr_a_i = '0;
        raddr_b_i = '0;
        ex_valid_i = 1'b1;  ex_waddr_i = 5'd3;  ex_wdata_i = 32'h33;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd4; lsu_wdata_i = 32'h44;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_we", rf_we_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_ready", ex_ready_o, 1);
        chk("rst_pending", pending_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fwd", {fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o}, 0);
        cyc();
        idle();
        rst_ni = 1'b1;
        cyc();
        cyc();

        // Bypass on an idle block.
        ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234;
        chk("byp_ready", ex_ready_o, 1);
        exp_wr(5'd5, 32'h1234, 1);
        cyc();
        idle();
        #1;
        chk("byp_pending", pending_o, 32'h0000_0020);
        chk("byp_busy", busy_o, 1);
        cyc();
        chk("byp_pending_clr", pending_o, 0);
        chk("byp_busy_clr", busy_o, 0);
        cyc();

        // LSU/EX collision on x7: LSU first, EX value final.
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'hAAAA;
        ex_valid_i  = 1'b1; ex_waddr_i  = 5'd7; ex_wdata_i  = 32'hBBBB;
        exp_wr(5'd7, 32'hAAAA, 1);
        exp_wr(5'd7, 32'hBBBB, 2);
        cyc();
        idle();
        raddr_a_i = 5'd7;
        raddr_b_i = 5'd5;
        #1;
        chk("col_hit_a", fwd_hit_a_o, FWD);
        chk("col_data_a", fwd_data_a_o, FWD ? 32'hBBBB : 32'h0);
        chk("col_hit_b", fwd_hit_b_o, 0);
        chk("col_pending", pending_o, 32'h0000_0080);
        cyc();
        chk("col_out_hit_a", fwd_hit_a_o, FWD);
        chk("col_out_data_a", fwd_data_a_o, FWD ? 32'hBBBB : 32'h0);
        cyc();
        chk("col_idle_hit_a", fwd_hit_a_o, 0);
        chk("col_idle_busy", busy_o, 0);
        cyc();

        // Backpressure: 5-cycle LSU burst while EX offers x1..x3.
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        base = cyc_n;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{a: 5'(10 + i), d: 32'hC000 + 32'(i), c: base + 1 + i});
        end
        sb.push_back('{a: 5'd1, d: 32'h101, c: base + 6});
        sb.push_back('{a: 5'd2, d: 32'h102, c: base + 7});
        sb.push_back('{a: 5'd3, d: 32'h103, c: base + 8});
        e = 0;
        for (int c = 0; c < 9; c++) begin
            lsu_valid_i = (c < 5);
            lsu_waddr_i = (c < 5) ? 5'(10 + c) : 5'd0;
            lsu_wdata_i = 32'hC000 + 32'(c);
            ex_valid_i  = (e < 3);
            ex_waddr_i  = 5'(e + 1);
            ex_wdata_i  = 32'h100 + 32'(e + 1);
            if (c < 8) chk($sformatf("bp_ready_c%0d", c), ex_ready_o, exp_rdy[c]);
            hs = ex_valid_i && ex_ready_o;
            cyc();
            if (hs) e++;
        end
        idle();
        chk("bp_accepted", e, 3);
        cyc();
        chk("bp_busy_end", busy_o, 0);

        // x0 filter on both sources.
        ex_valid_i  = 1'b1; ex_waddr_i  = 5'd0; ex_wdata_i  = 32'hFFFF;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'h1;
        raddr_a_i = 5'd0;
        chk("x0_ready", ex_ready_o, 1);
        cyc();
        idle();
        #1;
        chk("x0_we", rf_we_o, 0);
        chk("x0_pending", pending_o, 0);
        chk("x0_hit_a", fwd_hit_a_o, 0);
        cyc();
        chk("x0_busy", busy_o, 0);

        // Reset with two EX entries queued behind LSU traffic.
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd15; lsu_wdata_i = 32'h15;
        ex_valid_i  = 1'b1; ex_waddr_i  = 5'd20; ex_wdata_i  = 32'h20;
        exp_wr(5'd15, 32'h15, 1);
        exp_wr(5'd16, 32'h16, 2);
        cyc();
        lsu_waddr_i = 5'd16; lsu_wdata_i = 32'h16;
        ex_waddr_i  = 5'd21; ex_wdata_i  = 32'h21;
        cyc();
        idle();
        #1;
        chk("rq_pending", pending_o, (32'h1 << 20) | (32'h1 << 21) | (32'h1 << 16));
        chk("rq_ready", ex_ready_o, 0);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rq_async_we", rf_we_o, 0);
        chk("rq_async_pending", pending_o, 0);
        chk("rq_async_ready", ex_ready_o, 1);
        cyc();
        rst_ni = 1'b1;
        repeat (4) cyc();
        chk("rq_busy_after", busy_o, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
